// File: rtl/rgb_seq_pkg.sv
// rgb_seq_pkg: shared state/colour types, default palette and the one-unit channel step
package rgb_seq_pkg;
    typedef enum logic {RAMP, HOLD} state_t;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;
    localparam rgb_t PAL0 = 24'hFF0000;
    localparam rgb_t PAL1 = 24'h00FF00;
    localparam rgb_t PAL2 = 24'h0000FF;
    localparam rgb_t PAL3 = 24'hFFFFFF;
    function automatic logic [7:0] step8(input logic [7:0] c, input logic [7:0] t);
        return c < t ? c + 8'd1 : c > t ? c - 8'd1 : c;
    endfunction
    function automatic rgb_t step_toward(input rgb_t c, input rgb_t t);
        return '{r: step8(c.r, t.r), g: step8(c.g, t.g), b: step8(c.b, t.b)};
    endfunction
endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// rgb_fade_sequencer_if: control, palette-write and PWM duty signals of the sequencer
interface rgb_fade_sequencer_if;
    logic en;
    logic next_btn;
    logic wr_en;
    logic [1:0] wr_addr;
    logic [23:0] wr_data;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
    logic [1:0] idx;
    logic holding;
    modport master(output en, next_btn, wr_en, wr_addr, wr_data, input R, G, B, idx, holding);
    modport slave(input en, next_btn, wr_en, wr_addr, wr_data, output R, G, B, idx, holding);
endinterface

// File: rtl/rgb_fade_sequencer_tick_prescaler.sv
// tick_prescaler: one-cycle tick every DIV enabled cycles; count freezes while en is low
module tick_prescaler #(
    parameter int DIV = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick = en && cnt_q == LAST;
        cnt_d = tick ? '0 : en ? cnt_q + W'(1) : cnt_q;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: ramps the RGB PWM duties through a writable 4-entry palette with hold and skip
module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int TICK_DIV = 65536,
    parameter int HOLD_TICKS = 256
) (
    input logic clk,
    input logic rst,
    rgb_fade_sequencer_if.slave bus
);
    localparam int HW = HOLD_TICKS > 1 ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HLAST = HW'(HOLD_TICKS - 1);
    rgb_t pal_q [4];
    rgb_t pal_d [4];
    rgb_t col_q, col_d, nxt, tgt;
    state_t st_q, st_d;
    logic [1:0] idx_q, idx_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic btn_q, btn_d, press, tick;
    tick_prescaler #(.DIV(TICK_DIV)) u_pre (.clk(clk), .rst(rst), .en(bus.en), .tick(tick));
    always_comb begin
        pal_d = pal_q;
        if (bus.wr_en) pal_d[bus.wr_addr] = bus.wr_data;
        btn_d = bus.next_btn;
        press = bus.en && bus.next_btn && !btn_q;
        tgt = pal_q[idx_q];
        nxt = step_toward(col_q, tgt);
        col_d = col_q;
        st_d = st_q;
        idx_d = idx_q;
        hold_cnt_d = hold_cnt_q;
        // a button edge wins over a coincident tick: advance once, no channel step
        if (press) begin
            idx_d = idx_q + 2'd1;
            st_d = RAMP;
            hold_cnt_d = '0;
        end else if (tick && st_q == RAMP) begin
            col_d = nxt;
            if (nxt == tgt) begin
                st_d = HOLD;
                hold_cnt_d = '0;
            end
        end else if (tick) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
            if (hold_cnt_q == HLAST) begin
                idx_d = idx_q + 2'd1;
                st_d = RAMP;
                hold_cnt_d = '0;
            end
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pal_q <= '{PAL0, PAL1, PAL2, PAL3};
            col_q <= '0;
            st_q <= RAMP;
            idx_q <= '0;
            hold_cnt_q <= '0;
            btn_q <= 1'b0;
        end else begin
            pal_q <= pal_d;
            col_q <= col_d;
            st_q <= st_d;
            idx_q <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            btn_q <= btn_d;
        end
    assign bus.R = col_q.r;
    assign bus.G = col_q.g;
    assign bus.B = col_q.b;
    assign bus.idx = idx_q;
    assign bus.holding = st_q == HOLD;
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: directed phases push expected output changes; a monitor pops one per observed change
module tb_rgb_fade_sequencer;
    typedef struct {
        int cyc;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [1:0] idx;
        logic hold;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    bit armed = 1'b0;
    bit first = 1'b1;
    exp_t q[$];
    exp_t me, le;
    logic [26:0] cur, prev, want;
    rgb_fade_sequencer_if bus();
    rgb_fade_sequencer #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
    task automatic push(input int c, input int r, input int g, input int b, input int i, input int h);
        exp_t e;
        e.cyc = c;
        e.r = 8'(r);
        e.g = 8'(g);
        e.b = 8'(b);
        e.idx = 2'(i);
        e.hold = 1'(h);
        q.push_back(e);
    endtask
    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic reset_mid();
        push(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
    always @(negedge clk) if (armed) begin
        cur = {bus.R, bus.G, bus.B, bus.idx, bus.holding};
        if (first || cur !== prev) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change cyc=%0d got rgb=%h idx=%0d hold=%b", cyc, cur[26:3], cur[2:1], cur[0]);
            end else begin
                me = q.pop_front();
                want = {me.r, me.g, me.b, me.idx, me.hold};
                if (me.cyc != cyc || cur !== want) begin
                    miscompares++;
                    $display("FAIL output_change got cyc=%0d rgb=%h idx=%0d hold=%b, expected cyc=%0d rgb=%h idx=%0d hold=%b",
                             cyc, cur[26:3], cur[2:1], cur[0], me.cyc, want[26:3], want[2:1], want[0]);
                end
            end
        end
        prev = cur;
        first = 1'b0;
    end
    initial begin
        bus.en = 1'b1;
        bus.next_btn = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        push(0, 0, 0, 0, 0, 0);
        armed = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // full ramps 000000->FF0000->00FF00->0000FF, then reset mid-hold at idx 2
        for (int k = 1; k < 255; k++) push(4 * k, k, 0, 0, 0, 0);
        push(1020, 255, 0, 0, 0, 1);
        push(1028, 255, 0, 0, 1, 0);
        for (int j = 1; j < 255; j++) push(1028 + 4 * j, 255 - j, j, 0, 1, 0);
        push(2048, 0, 255, 0, 1, 1);
        push(2056, 0, 255, 0, 2, 0);
        for (int j = 1; j < 255; j++) push(2056 + 4 * j, 0, 255 - j, j, 2, 0);
        push(3076, 0, 0, 255, 2, 1);
        go(2100);
        bus.wr_en = 1'b1;
        bus.wr_addr = 2'd0;
        bus.wr_data = 24'h000080;
        go(2101);
        bus.wr_en = 1'b0;
        go(3078);
        reset_mid();
        // skip at R=40, freeze with ignored/held button, skip coinciding with a tick
        for (int k = 1; k <= 64; k++) push(4 * k, k, 0, 0, 0, 0);
        push(258, 'h40, 0, 0, 1, 0);
        for (int m = 1; m <= 3; m++) push(256 + 4 * m, 64 - m, m, 0, 1, 0);
        for (int m = 4; m <= 8; m++) push(372 + 4 * (m - 4), 64 - m, m, 0, 1, 0);
        push(392, 'h38, 8, 0, 2, 0);
        push(396, 'h37, 7, 1, 2, 0);
        push(400, 'h36, 6, 2, 2, 0);
        go(257);
        bus.next_btn = 1'b1;
        go(258);
        bus.next_btn = 1'b0;
        go(270);
        bus.en = 1'b0;
        go(300);
        bus.next_btn = 1'b1;
        go(301);
        bus.next_btn = 1'b0;
        go(350);
        bus.next_btn = 1'b1;
        go(370);
        bus.en = 1'b1;
        go(380);
        bus.next_btn = 1'b0;
        go(391);
        bus.next_btn = 1'b1;
        go(392);
        bus.next_btn = 1'b0;
        go(402);
        reset_mid();
        // retarget entry 0 mid-ramp, then rewrite it during HOLD
        for (int k = 1; k <= 16; k++) push(4 * k, k, 0, 0, 0, 0);
        for (int k = 17; k < 144; k++) push(4 * k, k <= 32 ? 32 - k : 0, 0, k - 16, 0, 0);
        push(576, 0, 0, 'h80, 0, 1);
        push(584, 0, 0, 'h80, 1, 0);
        push(588, 0, 1, 'h7F, 1, 0);
        go(64);
        bus.wr_en = 1'b1;
        bus.wr_addr = 2'd0;
        bus.wr_data = 24'h000080;
        go(65);
        bus.wr_en = 1'b0;
        go(578);
        bus.wr_en = 1'b1;
        bus.wr_data = 24'h123456;
        go(579);
        bus.wr_en = 1'b0;
        go(590);
        armed = 1'b0;
        while (q.size() > 0) begin
            le = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_change got none, expected cyc=%0d rgb=%h%h%h idx=%0d hold=%b", le.cyc, le.r, le.g, le.b, le.idx, le.hold);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
